// File: rtl/i2c_bus_conditioner.sv
// ---------------------------------------------------------------------------
// i2c_bus_conditioner
//
// Front end of the I2C slave. It synchronises the raw SCL/SDA pad inputs,
// deglitches each line with a debounce counter, and detects START / STOP
// conditions on the filtered lines. The detection state is held until the
// serial interface clears it.
//
// Ports:
//   clk                 system clock, all logic on posedge
//   rst_n               synchronous, active-low reset
//   sclIn, sdaIn        raw pad inputs (asynchronous to clk)
//   clearStartStopDet   level; returns the detection state to NULL_DET
//   sclOut, sdaOut      filtered SCL / SDA
//   startStopDetState   NULL_DET=00, START_DET=01, STOP_DET=10
//   startPulse          one-cycle pulse per START or repeated START
//   stopPulse           one-cycle pulse per STOP
//   busBusy             set by START, cleared by STOP
//
// Every output is driven straight from a flop.
// ---------------------------------------------------------------------------
module i2c_bus_conditioner #(
  parameter int DEB_LEN     = 4,  // 1..255
  parameter int SYNC_STAGES = 2   // 2..4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclIn,
  input  logic       sdaIn,
  input  logic       clearStartStopDet,
  output logic       sclOut,
  output logic       sdaOut,
  output logic [1:0] startStopDetState,
  output logic       startPulse,
  output logic       stopPulse,
  output logic       busBusy
);

  localparam int CNT_W = $clog2(DEB_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_LEN - 1);

  typedef enum logic [1:0] {
    NULL_DET  = 2'b00,
    START_DET = 2'b01,
    STOP_DET  = 2'b10
  } det_e;

  // One debounce step: returns {filtered_next, counter_next}. The counter
  // only runs while the synchronised value disagrees with the filtered one,
  // so any bounce back to the filtered value restarts the count.
  function automatic logic [CNT_W:0] deb_step(input logic             sync_v,
                                              input logic             filt_v,
                                              input logic [CNT_W-1:0] cnt_v);
    logic [CNT_W:0] res;
    if (sync_v == filt_v) begin
      res = {filt_v, {CNT_W{1'b0}}};
    end else if (cnt_v == CNT_LAST) begin
      res = {sync_v, {CNT_W{1'b0}}};
    end else begin
      res = {filt_v, cnt_v + CNT_W'(1)};
    end
    return res;
  endfunction

  logic [SYNC_STAGES-1:0] sclSync_q, sdaSync_q;
  logic [CNT_W-1:0]       sclCnt_q, sclCnt_d, sdaCnt_q, sdaCnt_d;
  logic                   sclFilt_q, sclFilt_d, sdaFilt_q, sdaFilt_d;
  logic                   sclPrev_q, sdaPrev_q;
  det_e                   state_q, state_d;
  logic                   startPulse_q, stopPulse_q, busBusy_q, busBusy_d;
  logic                   start_c, stop_c;

  // Synchroniser and debounce stage
  always_comb begin
    {sclFilt_d, sclCnt_d} = deb_step(sclSync_q[SYNC_STAGES-1], sclFilt_q, sclCnt_q);
    {sdaFilt_d, sdaCnt_d} = deb_step(sdaSync_q[SYNC_STAGES-1], sdaFilt_q, sdaCnt_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclSync_q <= '1;
      sdaSync_q <= '1;
      sclCnt_q  <= '0;
      sdaCnt_q  <= '0;
      sclFilt_q <= 1'b1;
      sdaFilt_q <= 1'b1;
      sclPrev_q <= 1'b1;
      sdaPrev_q <= 1'b1;
    end else begin
      sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], sclIn};
      sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sdaIn};
      sclCnt_q  <= sclCnt_d;
      sdaCnt_q  <= sdaCnt_d;
      sclFilt_q <= sclFilt_d;
      sdaFilt_q <= sdaFilt_d;
      sclPrev_q <= sclFilt_q;
      sdaPrev_q <= sdaFilt_q;
    end
  end

  // Condition detect stage: SCL must be high in both the previous and the
  // current cycle, so an SCL edge coinciding with an SDA edge is ignored.
  assign start_c = sclPrev_q & sclFilt_q &  sdaPrev_q & ~sdaFilt_q;
  assign stop_c  = sclPrev_q & sclFilt_q & ~sdaPrev_q &  sdaFilt_q;

  // A bus event always beats a simultaneous clear.
  always_comb begin
    state_d   = state_q;
    busBusy_d = busBusy_q;
    if (start_c) begin
      state_d   = START_DET;
      busBusy_d = 1'b1;
    end else if (stop_c) begin
      state_d   = STOP_DET;
      busBusy_d = 1'b0;
    end else if (clearStartStopDet) begin
      state_d   = NULL_DET;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= NULL_DET;
      startPulse_q <= 1'b0;
      stopPulse_q  <= 1'b0;
      busBusy_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      startPulse_q <= start_c;
      stopPulse_q  <= stop_c;
      busBusy_q    <= busBusy_d;
    end
  end

  assign sclOut            = sclFilt_q;
  assign sdaOut            = sdaFilt_q;
  assign startStopDetState = state_q;
  assign startPulse        = startPulse_q;
  assign stopPulse         = stopPulse_q;
  assign busBusy           = busBusy_q;

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// ---------------------------------------------------------------------------
// Testbench for i2c_bus_conditioner (default parameters DEB_LEN=4,
// SYNC_STAGES=2). The stimulus process queues every output change it expects,
// tagged with the cycle at which it must appear; a monitor pops an entry each
// time the output vector changes and compares value and cycle.
// Output vector: {sclOut, sdaOut, state[1:0], startPulse, stopPulse, busBusy}.
// ---------------------------------------------------------------------------
module tb_i2c_bus_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclIn, sdaIn, clearStartStopDet;
  logic       sclOut, sdaOut, startPulse, stopPulse, busBusy;
  logic [1:0] startStopDetState;

  i2c_bus_conditioner dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .sclIn             (sclIn),
    .sdaIn             (sdaIn),
    .clearStartStopDet (clearStartStopDet),
    .sclOut            (sclOut),
    .sdaOut            (sdaOut),
    .startStopDetState (startStopDetState),
    .startPulse        (startPulse),
    .stopPulse         (stopPulse),
    .busBusy           (busBusy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [6:0] v;
  } exp_t;
  exp_t q[$];

  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  // Bench model of the expected line / state values.
  bit       m_scl, m_sda, m_busy;
  bit [1:0] m_st;

  localparam int EV_NONE = 0, EV_START = 1, EV_STOP = 2;

  function automatic logic [6:0] mk(bit scl, bit sda, bit [1:0] st,
                                    bit sp, bit pp, bit b);
    return {scl, sda, st, sp, pp, b};
  endfunction

  task automatic push(int at, logic [6:0] v);
    exp_t e;
    e.at = at;
    e.v  = v;
    q.push_back(e);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Change one pad line; the filtered value follows 6 cycles later, and a
  // START/STOP shows up one cycle after that as a one-cycle pulse.
  task automatic drive(bit is_scl, bit v, int ev);
    int c;
    c = cyc;
    if (is_scl) begin
      sclIn = v;
      m_scl = v;
    end else begin
      sdaIn = v;
      m_sda = v;
    end
    push(c + 6, mk(m_scl, m_sda, m_st, 0, 0, m_busy));
    if (ev == EV_START) begin
      m_st = 2'b01; m_busy = 1'b1;
      push(c + 7, mk(m_scl, m_sda, m_st, 1, 0, m_busy));
      push(c + 8, mk(m_scl, m_sda, m_st, 0, 0, m_busy));
    end else if (ev == EV_STOP) begin
      m_st = 2'b10; m_busy = 1'b0;
      push(c + 7, mk(m_scl, m_sda, m_st, 0, 1, m_busy));
      push(c + 8, mk(m_scl, m_sda, m_st, 0, 0, m_busy));
    end
    tick(8);
  endtask

  // Monitor: every change of the output vector is one DUT presentation.
  logic [6:0] prev_v;
  bit         first = 1'b1;
  always @(negedge clk) begin
    logic [6:0] cur;
    exp_t       e;
    cur = {sclOut, sdaOut, startStopDetState, startPulse, stopPulse, busBusy};
    if (cyc >= 1 && !done && (first || cur !== prev_v)) begin
      first = 1'b0;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change cyc=%0d actual=%b expected=no change", cyc, cur);
      end else begin
        e = q.pop_front();
        if (cur !== e.v || cyc != e.at) begin
          failures++;
          $display("FAIL out_vec cyc=%0d actual=%b expected=%b at cyc %0d",
                   cyc, cur, e.v, e.at);
        end
      end
    end
    prev_v = cur;
  end

  initial begin
    logic [7:0] pat;
    int c;
    rst_n = 1'b0; sclIn = 1'b0; sdaIn = 1'b0; clearStartStopDet = 1'b0;
    m_scl = 1; m_sda = 1; m_st = 2'b00; m_busy = 0;
    // Reset values appear at the first edge.
    push(1, mk(1, 1, 2'b00, 0, 0, 0));
    tick(3);
    // Release with pads low: filtered lines drop 6 cycles later.
    rst_n = 1'b1;
    m_scl = 0; m_sda = 0;
    push(cyc + 6, mk(0, 0, 2'b00, 0, 0, 0));
    tick(10);
    // Both lines back high together: no STOP since SCL was low before.
    c = cyc; sclIn = 1; sdaIn = 1; m_scl = 1; m_sda = 1;
    push(c + 6, mk(1, 1, 2'b00, 0, 0, 0));
    tick(10);

    // 3-cycle SCL glitch is rejected.
    sclIn = 0; tick(3); sclIn = 1; tick(10);
    // Bounce: 3 low, 1 high, 3 low -> count restarts, still rejected.
    sclIn = 0; tick(3); sclIn = 1; tick(1); sclIn = 0; tick(3); sclIn = 1; tick(10);
    // 4-cycle low pulse passes: falls at +6, rises 6 cycles after the pad rise.
    c = cyc; sclIn = 0;
    push(c + 6,  mk(0, 1, 2'b00, 0, 0, 0));
    push(c + 10, mk(1, 1, 2'b00, 0, 0, 0));
    tick(4); sclIn = 1; tick(12);

    // START, then one byte with SDA moving only while SCL is low.
    drive(0, 0, EV_START);
    drive(1, 0, EV_NONE);
    pat = 8'hA6;
    for (int i = 7; i >= 0; i--) begin
      if (m_sda != pat[i]) drive(0, pat[i], EV_NONE);
      drive(1, 1, EV_NONE);
      drive(1, 0, EV_NONE);
    end
    // Repeated START: state stays START_DET with a second pulse.
    drive(0, 1, EV_NONE);
    drive(1, 1, EV_NONE);
    drive(0, 0, EV_START);

    // One-cycle clear returns to NULL_DET; busBusy is untouched.
    c = cyc; clearStartStopDet = 1'b1; m_st = 2'b00;
    push(c + 1, mk(m_scl, m_sda, m_st, 0, 0, m_busy));
    tick(1); clearStartStopDet = 1'b0; tick(3);

    // STOP from NULL_DET.
    drive(0, 1, EV_STOP);
    // START from STOP_DET.
    drive(0, 0, EV_START);

    // STOP coincides with a clear: the STOP wins.
    c = cyc; sdaIn = 1'b1; m_sda = 1;
    push(c + 6, mk(1, 1, 2'b01, 0, 0, 1));
    push(c + 7, mk(1, 1, 2'b10, 0, 1, 0));
    push(c + 8, mk(1, 1, 2'b10, 0, 0, 0));
    m_st = 2'b10; m_busy = 0;
    tick(6); clearStartStopDet = 1'b1; tick(1); clearStartStopDet = 1'b0; tick(4);

    // Clear held for several cycles: one change to NULL_DET, then steady.
    c = cyc; clearStartStopDet = 1'b1; m_st = 2'b00;
    push(c + 1, mk(1, 1, 2'b00, 0, 0, 0));
    tick(3); clearStartStopDet = 1'b0; tick(3);

    // SCL and SDA fall together: no START.
    c = cyc; sclIn = 0; sdaIn = 0;
    push(c + 6, mk(0, 0, 2'b00, 0, 0, 0));
    tick(10);
    // And rise together: no STOP.
    c = cyc; sclIn = 1; sdaIn = 1;
    push(c + 6, mk(1, 1, 2'b00, 0, 0, 0));
    tick(12);

    done = 1'b1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
